// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multi-cycle MIPS controller: FSM state encoding,
//   opcode/funct constants, instruction classes and the datapath select codes
//   (ALUCtrl, PCSel, RegDst, MemtoReg, ExtOp).
package mips_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_ADDU    = 4'd0,
    C_SUBU    = 4'd1,
    C_JR      = 4'd2,
    C_ORI     = 4'd3,
    C_LUI     = 4'd4,
    C_LW      = 4'd5,
    C_SW      = 4'd6,
    C_BEQ     = 4'd7,
    C_J       = 4'd8,
    C_JAL     = 4'd9,
    C_ILLEGAL = 4'd10
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_OR     = 4'd2;
  localparam logic [3:0] ALU_PASS_B = 4'd3;

  localparam logic [1:0] PCSEL_PC4    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_JUMP   = 2'd2;
  localparam logic [1:0] PCSEL_REG    = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// mc_decode
//   Pure combinational classifier: opcode/funct of the IR -> instruction class.
//   Anything outside the supported subset maps to C_ILLEGAL.
// Ports
//   i_opcode  in  6  Instr[31:26]
//   i_funct   in  6  Instr[5:0]
//   o_class   out 4  iclass_e code
module mc_decode (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_class
);
  import mips_pkg::*;

  // Opcode first; R-type is further split on funct.
  always_comb begin
    o_class = C_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_class = C_ADDU;
          FN_SUBU: o_class = C_SUBU;
          FN_JR:   o_class = C_JR;
          default: o_class = C_ILLEGAL;
        endcase
      end
      OP_ORI:  o_class = C_ORI;
      OP_LUI:  o_class = C_LUI;
      OP_LW:   o_class = C_LW;
      OP_SW:   o_class = C_SW;
      OP_BEQ:  o_class = C_BEQ;
      OP_J:    o_class = C_J;
      OP_JAL:  o_class = C_JAL;
      default: o_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequencing FSM for the multi-cycle MIPS datapath. Steps each instruction
//   through FETCH/DECODE/EXE/MEM/WB and turns (state, Instr, Zero) into
//   datapath strobes and mux selects. A data-memory access that never sees
//   mem_ready is abandoned after WAIT_MAX cycles with a bus_err pulse.
// Ports
//   clk, reset (async, active-low)
//   Instr[31:0], Zero, mem_ready                      inputs from datapath/memory
//   PCWrite, PCSel[1:0], IRWrite, RegWrite, RegDst[1:0], MemtoReg[1:0],
//   ExtOp[1:0], ALUSrc, ALUCtrl[3:0], MemRead, MemWrite datapath controls
//   instr_done, illegal, bus_err                      one-cycle status pulses
module multicycle_controller #(
  parameter int WAIT_MAX = 16,
  parameter int CW       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSel,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ExtOp,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err
);
  import mips_pkg::*;

  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_MAX - 1);

  state_e        r_state;
  state_e        w_nextState;
  logic [CW-1:0] r_waitCnt;
  logic [CW-1:0] w_nextWait;
  logic [3:0]    w_classRaw;
  iclass_e       w_class;

  mc_decode u_decode (
    .i_opcode (Instr[31:26]),
    .i_funct  (Instr[5:0]),
    .o_class  (w_classRaw)
  );

  assign w_class = iclass_e'(w_classRaw);

  // State and MEM wait counter; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWait;
    end
  end

  // Next state and all outputs. The wait counter only survives while the FSM
  // stays in MEM, so every exit from MEM clears it implicitly.
  always_comb begin
    w_nextState = S_FETCH;
    w_nextWait  = '0;
    PCWrite     = 1'b0;
    PCSel       = PCSEL_PC4;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = WD_ALU;
    ExtOp       = EXT_ZERO;
    ALUSrc      = 1'b0;
    ALUCtrl     = ALU_ADD;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;

    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        PCWrite     = 1'b1;
        PCSel       = PCSEL_PC4;
        w_nextState = S_DECODE;
      end

      S_DECODE: begin
        case (w_class)
          C_J: begin
            PCWrite    = 1'b1;
            PCSel      = PCSEL_JUMP;
            instr_done = 1'b1;
          end
          C_JAL: begin
            PCWrite    = 1'b1;
            PCSel      = PCSEL_JUMP;
            RegWrite   = 1'b1;
            RegDst     = REGDST_RA;
            MemtoReg   = WD_PC4;
            instr_done = 1'b1;
          end
          C_JR: begin
            PCWrite    = 1'b1;
            PCSel      = PCSEL_REG;
            instr_done = 1'b1;
          end
          C_ILLEGAL: illegal = 1'b1;
          default:   w_nextState = S_EXE;
        endcase
      end

      S_EXE: begin
        case (w_class)
          C_ADDU: begin
            ALUCtrl     = ALU_ADD;
            w_nextState = S_WB;
          end
          C_SUBU: begin
            ALUCtrl     = ALU_SUB;
            w_nextState = S_WB;
          end
          C_ORI: begin
            ALUCtrl     = ALU_OR;
            ExtOp       = EXT_ZERO;
            ALUSrc      = 1'b1;
            w_nextState = S_WB;
          end
          C_LUI: begin
            ALUCtrl     = ALU_PASS_B;
            ExtOp       = EXT_UPPER;
            ALUSrc      = 1'b1;
            w_nextState = S_WB;
          end
          C_LW, C_SW: begin
            ALUCtrl     = ALU_ADD;
            ExtOp       = EXT_SIGN;
            ALUSrc      = 1'b1;
            w_nextState = S_MEM;
          end
          C_BEQ: begin
            ALUCtrl    = ALU_SUB;
            PCWrite    = Zero;
            PCSel      = PCSEL_BRANCH;
            instr_done = 1'b1;
          end
          default: w_nextState = S_FETCH;
        endcase
      end

      // mem_ready on the timeout cycle still counts as a normal completion.
      S_MEM: begin
        MemRead  = (w_class == C_LW);
        MemWrite = (w_class == C_SW);
        if (mem_ready) begin
          if (w_class == C_LW) begin
            w_nextState = S_WB;
          end else begin
            instr_done = 1'b1;
          end
        end else if (r_waitCnt == LAST_WAIT) begin
          bus_err = 1'b1;
        end else begin
          w_nextState = S_MEM;
          w_nextWait  = r_waitCnt + CW'(1);
        end
      end

      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        if (w_class == C_ADDU || w_class == C_SUBU) begin
          RegDst = REGDST_RD;
        end
        if (w_class == C_LW) begin
          MemtoReg = WD_MDR;
        end
      end

      default: w_nextState = S_FETCH;
    endcase

    // Outputs are forced quiet for as long as reset is held, so an in-flight
    // memory request disappears the instant reset asserts.
    if (!reset) begin
      PCWrite    = 1'b0;
      PCSel      = PCSEL_PC4;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = REGDST_RT;
      MemtoReg   = WD_ALU;
      ExtOp      = EXT_ZERO;
      ALUSrc     = 1'b0;
      ALUCtrl    = ALU_ADD;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Drives whole instructions through the controller and summarises what the
//   controller did for each one (cycle count, strobe counts, selects seen),
//   then compares that summary with an instruction-level reference model.
module tb_multicycle_controller;

  localparam int WAIT_MAX = 16;
  localparam int BUDGET   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic [1:0]  PCSel;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [1:0]  ExtOp;
  logic        ALUSrc;
  logic [3:0]  ALUCtrl;
  logic        MemRead;
  logic        MemWrite;
  logic        instr_done;
  logic        illegal;
  logic        bus_err;
  logic [20:0] allOut;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] doneCnt;
    logic [3:0] illCnt;
    logic [3:0] busErrCnt;
    logic [7:0] rdCycles;
    logic [7:0] wrCycles;
    logic [3:0] irCycles;
    logic [3:0] pcCycles;
    logic [1:0] jumpSel;
    logic [3:0] regCycles;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [3:0] aluCtrl;
    logic       aluSrc;
    logic [1:0] extOp;
    logic       fetchOk;
  } obs_t;

  obs_t obs;
  obs_t exp;

  multicycle_controller #(.WAIT_MAX(WAIT_MAX), .CW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCSel      (PCSel),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ExtOp      (ExtOp),
    .ALUSrc     (ALUSrc),
    .ALUCtrl    (ALUCtrl),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  assign allOut = {PCWrite, PCSel, IRWrite, RegWrite, RegDst, MemtoReg, ExtOp,
                   ALUSrc, ALUCtrl, MemRead, MemWrite, instr_done, illegal, bus_err};

  always #5 clk = ~clk;

  function automatic logic [31:0] encR(input logic [5:0] fn);
    encR = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op);
    encI = {op, 5'($urandom), 5'($urandom), 16'($urandom)};
  endfunction

  // What one instruction should look like from the outside, derived from the
  // instruction's meaning: how long it takes, what it writes and where.
  // delay = number of MEM cycles without mem_ready before it arrives.
  function automatic obs_t model(input logic [31:0] ins, input logic z, input int delay);
    obs_t e;
    int w;
    bit tmo;
    logic [5:0] op;
    logic [5:0] fn;
    op  = ins[31:26];
    fn  = ins[5:0];
    e   = '0;
    e.irCycles = 4'd1;
    e.pcCycles = 4'd1;
    e.fetchOk  = 1'b1;
    tmo = (delay >= WAIT_MAX);
    w   = tmo ? WAIT_MAX : delay + 1;
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      e.cycles = 8'd4; e.doneCnt = 4'd1; e.regCycles = 4'd1; e.regDst = 2'd1;
      e.aluCtrl = (fn == 6'h21) ? 4'd0 : 4'd1;
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.cycles = 8'd2; e.doneCnt = 4'd1; e.pcCycles = 4'd2; e.jumpSel = 2'd3;
    end else if (op == 6'h0d) begin
      e.cycles = 8'd4; e.doneCnt = 4'd1; e.regCycles = 4'd1;
      e.aluCtrl = 4'd2; e.aluSrc = 1'b1; e.extOp = 2'd0;
    end else if (op == 6'h0f) begin
      e.cycles = 8'd4; e.doneCnt = 4'd1; e.regCycles = 4'd1;
      e.aluCtrl = 4'd3; e.aluSrc = 1'b1; e.extOp = 2'd2;
    end else if (op == 6'h23) begin
      e.aluSrc = 1'b1; e.extOp = 2'd1; e.rdCycles = 8'(w);
      if (tmo) begin
        e.cycles = 8'(3 + w); e.busErrCnt = 4'd1;
      end else begin
        e.cycles = 8'(4 + w); e.doneCnt = 4'd1; e.regCycles = 4'd1; e.memtoReg = 2'd1;
      end
    end else if (op == 6'h2b) begin
      e.aluSrc = 1'b1; e.extOp = 2'd1; e.wrCycles = 8'(w); e.cycles = 8'(3 + w);
      if (tmo) e.busErrCnt = 4'd1;
      else     e.doneCnt   = 4'd1;
    end else if (op == 6'h04) begin
      e.cycles = 8'd3; e.doneCnt = 4'd1; e.aluCtrl = 4'd1; e.jumpSel = 2'd1;
      e.pcCycles = z ? 4'd2 : 4'd1;
    end else if (op == 6'h02) begin
      e.cycles = 8'd2; e.doneCnt = 4'd1; e.pcCycles = 4'd2; e.jumpSel = 2'd2;
    end else if (op == 6'h03) begin
      e.cycles = 8'd2; e.doneCnt = 4'd1; e.pcCycles = 4'd2; e.jumpSel = 2'd2;
      e.regCycles = 4'd1; e.regDst = 2'd2; e.memtoReg = 2'd2;
    end else begin
      e.cycles = 8'd2; e.illCnt = 4'd1;
    end
    return e;
  endfunction

  // Runs one instruction starting in its FETCH cycle (called just after a
  // rising edge) and records what the controller did into obs.
  task automatic applyStimulus(input logic [31:0] ins, input logic z, input int delay);
    bit done;
    int k;
    obs  = '0;
    done = 1'b0;
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      k     = cyc - 3;
      Instr = ins;
      Zero  = (cyc == 2) ? z : 1'($urandom_range(0, 1));
      if (cyc < 3)        mem_ready = 1'($urandom_range(0, 1));
      else if (k < delay) mem_ready = 1'b0;
      else if (k == delay) mem_ready = 1'b1;
      else                mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 0) obs.fetchOk = IRWrite && PCWrite && (PCSel == 2'd0);
      if (cyc == 2) begin
        obs.aluCtrl = ALUCtrl;
        obs.aluSrc  = ALUSrc;
        obs.extOp   = ExtOp;
      end
      if (cyc > 0 && PCSel != 2'd0) obs.jumpSel = PCSel;
      if (RegWrite) begin
        obs.regDst   = RegDst;
        obs.memtoReg = MemtoReg;
      end
      obs.irCycles  = obs.irCycles  + 4'(IRWrite);
      obs.pcCycles  = obs.pcCycles  + 4'(PCWrite);
      obs.regCycles = obs.regCycles + 4'(RegWrite);
      obs.rdCycles  = obs.rdCycles  + 8'(MemRead);
      obs.wrCycles  = obs.wrCycles  + 8'(MemWrite);
      obs.doneCnt   = obs.doneCnt   + 4'(instr_done);
      obs.illCnt    = obs.illCnt    + 4'(illegal);
      obs.busErrCnt = obs.busErrCnt + 4'(bus_err);
      if (instr_done || illegal || bus_err) begin
        done       = 1'b1;
        obs.cycles = 8'(cyc + 1);
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL instr_end instr=%h no end pulse within %0d cycles, required one", ins, BUDGET);
      reset = 1'b0;
      #2;
      reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    Instr     = 32'h8C430004;
    Zero      = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (allOut !== 21'd0) begin
      nFail++; $display("[TB] FAIL reset_outputs got %h want 0", allOut);
    end
    Instr = 32'hAC430004;
    @(negedge clk);
    nChecks++;
    if (allOut !== 21'd0) begin
      nFail++; $display("[TB] FAIL reset_outputs_sw got %h want 0", allOut);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    nChecks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || PCSel !== 2'd0) begin
      nFail++; $display("[TB] FAIL reset_release_fetch got IRWrite=%b PCWrite=%b PCSel=%0d want 1 1 0",
                        IRWrite, PCWrite, PCSel);
    end
  endtask

  task automatic test_addu();
    applyStimulus(32'h00221821, 1'b0, 0);
    nChecks++;
    if (obs.cycles !== 8'd4) begin
      nFail++; $display("[TB] FAIL addu_cycles got %0d want 4", obs.cycles);
    end
    nChecks++;
    if (obs.regCycles !== 4'd1 || obs.regDst !== 2'd1 || obs.memtoReg !== 2'd0) begin
      nFail++; $display("[TB] FAIL addu_wb got RegWrite cycles=%0d RegDst=%0d MemtoReg=%0d want 1 1 0",
                        obs.regCycles, obs.regDst, obs.memtoReg);
    end
    nChecks++;
    if (obs.doneCnt !== 4'd1) begin
      nFail++; $display("[TB] FAIL addu_done got %0d want 1", obs.doneCnt);
    end
  endtask

  task automatic test_lw_wait();
    applyStimulus(32'h8C430004, 1'b0, 2);
    nChecks++;
    if (obs.rdCycles !== 8'd3) begin
      nFail++; $display("[TB] FAIL lw_memread_cycles got %0d want 3", obs.rdCycles);
    end
    nChecks++;
    if (obs.memtoReg !== 2'd1 || obs.regDst !== 2'd0 || obs.regCycles !== 4'd1) begin
      nFail++; $display("[TB] FAIL lw_wb got MemtoReg=%0d RegDst=%0d RegWrite cycles=%0d want 1 0 1",
                        obs.memtoReg, obs.regDst, obs.regCycles);
    end
    nChecks++;
    if (obs.cycles !== 8'd7 || obs.doneCnt !== 4'd1) begin
      nFail++; $display("[TB] FAIL lw_cycles got %0d done=%0d want 7 done=1", obs.cycles, obs.doneCnt);
    end
    // Ready arriving on the very last permitted cycle completes normally.
    applyStimulus(32'h8C430004, 1'b0, WAIT_MAX - 1);
    nChecks++;
    if (obs.busErrCnt !== 4'd0 || obs.doneCnt !== 4'd1 || obs.rdCycles !== 8'(WAIT_MAX)) begin
      nFail++; $display("[TB] FAIL lw_last_ready got bus_err=%0d done=%0d MemRead cycles=%0d want 0 1 %0d",
                        obs.busErrCnt, obs.doneCnt, obs.rdCycles, WAIT_MAX);
    end
  endtask

  task automatic test_beq();
    applyStimulus(32'h10220003, 1'b1, 0);
    nChecks++;
    if (obs.pcCycles !== 4'd2 || obs.jumpSel !== 2'd1 || obs.cycles !== 8'd3 || obs.doneCnt !== 4'd1) begin
      nFail++; $display("[TB] FAIL beq_taken got PCWrite cycles=%0d PCSel=%0d cycles=%0d done=%0d want 2 1 3 1",
                        obs.pcCycles, obs.jumpSel, obs.cycles, obs.doneCnt);
    end
    applyStimulus(32'h10220003, 1'b0, 0);
    nChecks++;
    if (obs.pcCycles !== 4'd1 || obs.jumpSel !== 2'd1 || obs.cycles !== 8'd3 || obs.doneCnt !== 4'd1) begin
      nFail++; $display("[TB] FAIL beq_not_taken got PCWrite cycles=%0d PCSel=%0d cycles=%0d done=%0d want 1 1 3 1",
                        obs.pcCycles, obs.jumpSel, obs.cycles, obs.doneCnt);
    end
  endtask

  task automatic test_jal();
    applyStimulus(32'h0C000010, 1'b0, 0);
    nChecks++;
    if (obs.cycles !== 8'd2 || obs.pcCycles !== 4'd2 || obs.jumpSel !== 2'd2) begin
      nFail++; $display("[TB] FAIL jal_pc got cycles=%0d PCWrite cycles=%0d PCSel=%0d want 2 2 2",
                        obs.cycles, obs.pcCycles, obs.jumpSel);
    end
    nChecks++;
    if (obs.regCycles !== 4'd1 || obs.regDst !== 2'd2 || obs.memtoReg !== 2'd2) begin
      nFail++; $display("[TB] FAIL jal_link got RegWrite cycles=%0d RegDst=%0d MemtoReg=%0d want 1 2 2",
                        obs.regCycles, obs.regDst, obs.memtoReg);
    end
  endtask

  task automatic test_timeout();
    applyStimulus(32'hAC430004, 1'b0, 1000);
    nChecks++;
    if (obs.busErrCnt !== 4'd1 || obs.doneCnt !== 4'd0) begin
      nFail++; $display("[TB] FAIL sw_timeout got bus_err=%0d done=%0d want 1 0", obs.busErrCnt, obs.doneCnt);
    end
    nChecks++;
    if (obs.wrCycles !== 8'(WAIT_MAX) || obs.cycles !== 8'(3 + WAIT_MAX)) begin
      nFail++; $display("[TB] FAIL sw_timeout_len got MemWrite cycles=%0d cycles=%0d want %0d %0d",
                        obs.wrCycles, obs.cycles, WAIT_MAX, 3 + WAIT_MAX);
    end
    // The next instruction must start from a clean FETCH after the abort.
    applyStimulus(32'h00221821, 1'b0, 0);
    exp = model(32'h00221821, 1'b0, 0);
    nChecks++;
    if (obs !== exp) begin
      nFail++; $display("[TB] FAIL after_timeout got %h want %h", obs, exp);
    end
  endtask

  task automatic test_illegal();
    applyStimulus(32'hFC000000, 1'b0, 0);
    nChecks++;
    if (obs.illCnt !== 4'd1 || obs.doneCnt !== 4'd0 || obs.cycles !== 8'd2) begin
      nFail++; $display("[TB] FAIL illegal_op got illegal=%0d done=%0d cycles=%0d want 1 0 2",
                        obs.illCnt, obs.doneCnt, obs.cycles);
    end
  endtask

  task automatic test_reset_mid_mem();
    for (int cyc = 0; cyc < 5; cyc++) begin
      Instr     = 32'hAC430004;
      Zero      = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      if (cyc < 4) begin
        @(posedge clk);
        #1;
      end
    end
    nChecks++;
    if (MemWrite !== 1'b1) begin
      nFail++; $display("[TB] FAIL mid_mem_write got %b want 1", MemWrite);
    end
    #1;
    reset = 1'b0;
    #1;
    nChecks++;
    if (MemWrite !== 1'b0 || allOut !== 21'd0) begin
      nFail++; $display("[TB] FAIL mid_mem_reset got MemWrite=%b outputs=%h want 0 0", MemWrite, allOut);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    nChecks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      nFail++; $display("[TB] FAIL mid_mem_refetch got IRWrite=%b PCWrite=%b want 1 1", IRWrite, PCWrite);
    end
    applyStimulus(32'h3C0A1234, 1'b0, 0);
    exp = model(32'h3C0A1234, 1'b0, 0);
    nChecks++;
    if (obs !== exp) begin
      nFail++; $display("[TB] FAIL mid_mem_next_instr got %h want %h", obs, exp);
    end
  endtask

  // Back-to-back random instructions, including illegal encodings, late
  // memory, last-cycle ready and timeouts.
  task automatic test_random();
    logic [31:0] ins;
    logic        z;
    int          delay;
    int          sel;
    logic [5:0]  badOps [4];
    badOps[0] = 6'h3F; badOps[1] = 6'h01; badOps[2] = 6'h08; badOps[3] = 6'h20;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0:  ins = encR(6'h21);
        1:  ins = encR(6'h23);
        2:  ins = encR(6'h08);
        3:  ins = encI(6'h0d);
        4:  ins = encI(6'h0f);
        5:  ins = encI(6'h23);
        6:  ins = encI(6'h2b);
        7:  ins = encI(6'h04);
        8:  ins = encI(6'h02);
        9:  ins = encI(6'h03);
        10: ins = encI(badOps[$urandom_range(0, 3)]);
        default: ins = encR(6'h20);
      endcase
      z = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       delay = WAIT_MAX - 1;
        1:       delay = WAIT_MAX + 3;
        default: delay = $urandom_range(0, 4);
      endcase
      applyStimulus(ins, z, delay);
      exp = model(ins, z, delay);
      nChecks++;
      if (obs !== exp) begin
        nFail++; $display("[TB] FAIL random_%0d instr=%h zero=%b delay=%0d got %h want %h",
                          n, ins, z, delay, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
